alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Downstream of the keypad/arming block.
- Consumes its registered is_enabled arm level, plus the same door and facility motion sensors.
- Sequences exit delay, entry delay, alarm, and siren timeout.
- Drives siren, strobe, armed LED, and a req/ack dispatch handshake to the authorities-notification interface.

Parameters:
- EXIT_DELAY_CYC, 16: cycles from arm until sensors are live.
- ENTRY_DELAY_CYC, 8: grace cycles after a door trip before alarm.
- SIREN_TIMEOUT_CYC, 64: cycles siren sounds before auto-silence.
- STROBE_DIV, 4: strobe toggles every STROBE_DIV cycles in ALARM.
- CNT_W, 8: width of the shared delay timer; every *_CYC value must be ≤ 2^CNT_W.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- is_enabled, input, 1: arm level from keypad; 1 = armed, 0 = disarmed.
- door_movement_detected, input, 1: door sensor, level.
- facility_movement_detected, input, 1: interior motion sensor, level.
- dispatch_ack, input, 1: authorities interface accepted request.
- state, output, 3: current FSM state encoding.
- siren, output, 1: siren drive.
- strobe, output, 1: strobe light drive.
- armed_led, output, 1: 1 whenever state ≠ DISARMED.
- dispatch_req, output, 1: request to notify authorities.
- alarm_count, output, 4: number of ALARM entries since reset, saturating.

Behaviour:
- Reset (async, immediate): state=DISARMED; timer=0; all outputs 0; alarm_count=0. Reset mid-operation aborts everything, including a pending dispatch_req.
- All outputs are registered. Outputs reflect the new state on the same edge that enters it.
- State encoding:
  - DISARMED=0
  - EXIT_DELAY=1
  - ARMED=2
  - ENTRY_DELAY=3
  - ALARM=4
  - SILENCED=5
  - 6 and 7 are illegal and recover to DISARMED.
- Global rule: is_enabled=0 sampled in any state → DISARMED next edge; siren=0, strobe=0. Highest priority.
- Timer: loaded with N-1 on state entry, decrements each cycle, "expired" when 0. A state with parameter N therefore lasts exactly N cycles.
- DISARMED: is_enabled=1 → EXIT_DELAY (load EXIT_DELAY_CYC-1).
- EXIT_DELAY:
  - Sensors are ignored.
  - On expiry → ARMED.
- ARMED:
  - facility=1 → ALARM.
  - Otherwise door=1 → ENTRY_DELAY (load ENTRY_DELAY_CYC-1).
  - Both asserted in the same cycle → ALARM (facility has priority).
- ENTRY_DELAY:
  - facility=1 → ALARM immediately.
  - Door activity is ignored.
  - On expiry → ALARM.
- ALARM entry:
  - Load SIREN_TIMEOUT_CYC-1.
  - siren=1; strobe=1, then toggles every STROBE_DIV cycles.
  - alarm_count increments, saturating at 15.
  - dispatch_req set to 1.
- ALARM on expiry → SILENCED:
  - siren=0, strobe held 1.
  - Any sensor=1 while SILENCED → ALARM again (full re-entry: count, timer, request).
- dispatch_req handshake:
  - Once set, held until dispatch_ack=1 is sampled; cleared on that edge.
  - Not cleared by disarm; only rst or ack clears it.
  - Re-entry to ALARM while already pending keeps it 1 and issues no duplicate pulse.
  - Ack sampled on the same edge as an ALARM re-entry leaves dispatch_req at 1 (set wins).
  - dispatch_ack while dispatch_req=0 is ignored.

Optional Feature:
- Macro: ALARM_CHIRP_EN.
- Defined: during ENTRY_DELAY, siren pulses high for 1 cycle every STROBE_DIV cycles, starting on the entry edge. This is the warning chirp.
- Undefined: siren=0 throughout ENTRY_DELAY.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then is_enabled=1 → state=1 and armed_led=1 on next edge; state=2 exactly 16 cycles later. A door pulse during EXIT_DELAY has no effect.
- ARMED, 1-cycle door pulse → state=3. is_enabled=0 at cycle 5 of entry delay → state=0 next edge; siren, dispatch_req and alarm_count all stay 0.
- ARMED, door pulse, no disarm → state=4 after 8 cycles:
  - siren=1, alarm_count=1.
  - strobe period 8 cycles.
  - dispatch_req=1 held until ack is pulsed at cycle 20, then cleared on that edge.
- ARMED, door and facility in the same cycle → state=4 on next edge with no ENTRY_DELAY; alarm_count=1.
- ALARM for 64 cycles → state=5, siren=0, strobe=1. Then a facility pulse → state=4, siren=1, alarm_count=2; dispatch_req is re-raised if it was previously acked.
- rst asserted mid-ALARM with dispatch_req=1 → all outputs 0 asynchronously, state=0, alarm_count=0. With ALARM_CHIRP_EN defined, rerun the entry-delay case and check 2 one-cycle siren chirps during the 8-cycle window.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm sequencer: exit delay, entry delay, alarm, siren timeout, dispatch handshake.
// Optional warning chirp during entry delay when ALARM_CHIRP_EN is defined.
module alarm_controller #(
  parameter int EXIT_DELAY_CYC    = 16,
  parameter int ENTRY_DELAY_CYC   = 8,
  parameter int SIREN_TIMEOUT_CYC = 64,
  parameter int STROBE_DIV        = 4,
  parameter int CNT_W             = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_enabled,
  input  logic       door_movement_detected,
  input  logic       facility_movement_detected,
  input  logic       dispatch_ack,
  output logic [2:0] state,
  output logic       siren,
  output logic       strobe,
  output logic       armed_led,
  output logic       dispatch_req,
  output logic [3:0] alarm_count
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_SILENCED = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] L_EXIT  = CNT_W'(EXIT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] L_ENTRY = CNT_W'(ENTRY_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] L_SIREN = CNT_W'(SIREN_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] L_DIV   = CNT_W'(STROBE_DIV - 1);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_div;
  logic             r_siren;
  logic             r_strobe;
  logic             r_armed_led;
  logic             r_dispatch_req;
  logic [3:0]       r_alarm_count;

  logic             w_expired;
  logic             w_go_alarm;

  assign w_expired = (r_timer == '0);

  // Every path into ALARM shares one entry action, so it is decoded once here.
  always_comb begin
    w_go_alarm = 1'b0;
    case (r_state)
      S_ARMED:    w_go_alarm = facility_movement_detected;
      S_ENTRY:    w_go_alarm = facility_movement_detected | w_expired;
      S_SILENCED: w_go_alarm = facility_movement_detected | door_movement_detected;
      default:    w_go_alarm = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_DISARMED;
      r_timer        <= '0;
      r_div          <= '0;
      r_siren        <= 1'b0;
      r_strobe       <= 1'b0;
      r_armed_led    <= 1'b0;
      r_dispatch_req <= 1'b0;
      r_alarm_count  <= 4'd0;
    end else begin
      // Ack clears first; an ALARM entry on the same edge overrides it below.
      if (dispatch_ack) r_dispatch_req <= 1'b0;

      if (!is_enabled) begin
        r_state     <= S_DISARMED;
        r_timer     <= '0;
        r_div       <= '0;
        r_siren     <= 1'b0;
        r_strobe    <= 1'b0;
        r_armed_led <= 1'b0;
      end else if (w_go_alarm) begin
        r_state        <= S_ALARM;
        r_timer        <= L_SIREN;
        r_div          <= L_DIV;
        r_siren        <= 1'b1;
        r_strobe       <= 1'b1;
        r_armed_led    <= 1'b1;
        r_dispatch_req <= 1'b1;
        if (r_alarm_count != 4'hF) r_alarm_count <= r_alarm_count + 4'd1;
      end else begin
        case (r_state)
          S_DISARMED: begin
            r_state     <= S_EXIT;
            r_timer     <= L_EXIT;
            r_armed_led <= 1'b1;
          end
          S_EXIT: begin
            if (w_expired) r_state <= S_ARMED;
            else           r_timer <= r_timer - L_ONE;
          end
          S_ARMED: begin
            if (door_movement_detected) begin
              r_state <= S_ENTRY;
              r_timer <= L_ENTRY;
              r_div   <= L_DIV;
`ifdef ALARM_CHIRP_EN
              r_siren <= 1'b1;
`endif
            end
          end
          S_ENTRY: begin
            r_timer <= r_timer - L_ONE;
`ifdef ALARM_CHIRP_EN
            if (r_div == '0) begin
              r_siren <= 1'b1;
              r_div   <= L_DIV;
            end else begin
              r_siren <= 1'b0;
              r_div   <= r_div - L_ONE;
            end
`endif
          end
          S_ALARM: begin
            if (w_expired) begin
              r_state  <= S_SILENCED;
              r_siren  <= 1'b0;
              r_strobe <= 1'b1;
            end else begin
              r_timer <= r_timer - L_ONE;
              if (r_div == '0) begin
                r_strobe <= ~r_strobe;
                r_div    <= L_DIV;
              end else begin
                r_div <= r_div - L_ONE;
              end
            end
          end
          S_SILENCED: begin
            r_state <= S_SILENCED;
          end
          default: begin
            r_state     <= S_DISARMED;
            r_timer     <= '0;
            r_div       <= '0;
            r_siren     <= 1'b0;
            r_strobe    <= 1'b0;
            r_armed_led <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state        = r_state;
  assign siren        = r_siren;
  assign strobe       = r_strobe;
  assign armed_led    = r_armed_led;
  assign dispatch_req = r_dispatch_req;
  assign alarm_count  = r_alarm_count;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller; expected values hand-derived from the timing rules.
module tb_alarm_controller;

  logic       clk, rst, is_enabled, door, fac, ack;
  logic [2:0] state;
  logic       siren, strobe, armed_led, dispatch_req;
  logic [3:0] alarm_count;

  int n_tests = 0;
  int n_fail  = 0;
  int chirps;
  int exp_chirps;

  alarm_controller dut (
    .clk                        (clk),
    .rst                        (rst),
    .is_enabled                 (is_enabled),
    .door_movement_detected     (door),
    .facility_movement_detected (fac),
    .dispatch_ack               (ack),
    .state                      (state),
    .siren                      (siren),
    .strobe                     (strobe),
    .armed_led                  (armed_led),
    .dispatch_req               (dispatch_req),
    .alarm_count                (alarm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef ALARM_CHIRP_EN
    exp_chirps = 2;
`else
    exp_chirps = 0;
`endif
    rst = 1'b1; is_enabled = 1'b0; door = 1'b0; fac = 1'b0; ack = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_outs", {siren, strobe, armed_led, dispatch_req}, 0);
    chk("rst_count", alarm_count, 0);
    tick(2);
    rst = 1'b0;

    // Arm, exit delay lasts 16 cycles, door ignored.
    is_enabled = 1'b1;
    tick(1);
    chk("arm_state", state, 1);
    chk("arm_led", armed_led, 1);
    door = 1'b1;
    tick(1);
    door = 1'b0;
    chk("exit_door_ignored", state, 1);
    tick(14);
    chk("exit_e15", state, 1);
    tick(1);
    chk("exit_done", state, 2);

    // Entry delay aborted by disarm at cycle 5.
    door = 1'b1;
    tick(1);
    door = 1'b0;
    chk("entry_state", state, 3);
    chk("entry_siren0", siren, exp_chirps != 0 ? 1 : 0);
    tick(4);
    is_enabled = 1'b0;
    tick(1);
    chk("disarm_state", state, 0);
    chk("disarm_outs", {siren, dispatch_req, armed_led}, 0);
    chk("disarm_count", alarm_count, 0);

    // Rearm, entry delay runs out into ALARM.
    is_enabled = 1'b1;
    tick(1);
    chk("rearm_state", state, 1);
    tick(16);
    chk("rearm_armed", state, 2);
    door = 1'b1;
    tick(1);
    door = 1'b0;
    chirps = int'(siren);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chirps += int'(siren);
    end
    chk("entry_chirps", chirps, exp_chirps);
    chk("entry_e7", state, 3);
    tick(1);
    chk("alarm_state", state, 4);
    chk("alarm_siren", siren, 1);
    chk("alarm_strobe_h0", strobe, 1);
    chk("alarm_count1", alarm_count, 1);
    chk("alarm_req", dispatch_req, 1);
    tick(3);
    chk("strobe_h3", strobe, 1);
    tick(1);
    chk("strobe_h4", strobe, 0);
    tick(3);
    chk("strobe_h7", strobe, 0);
    tick(1);
    chk("strobe_h8", strobe, 1);
    tick(11);
    chk("req_held_h19", dispatch_req, 1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("req_acked_h20", dispatch_req, 0);
    chk("alarm_h20", state, 4);
    tick(43);
    chk("alarm_h63", state, 4);
    chk("strobe_h63", strobe, 0);
    tick(1);
    chk("silenced_state", state, 5);
    chk("silenced_siren", siren, 0);
    chk("silenced_strobe", strobe, 1);
    tick(3);
    chk("silenced_hold", state, 5);
    fac = 1'b1;
    tick(1);
    fac = 1'b0;
    chk("reentry_state", state, 4);
    chk("reentry_siren", siren, 1);
    chk("reentry_count2", alarm_count, 2);
    chk("reentry_req", dispatch_req, 1);

    // Asynchronous reset mid-ALARM.
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_outs", {siren, strobe, armed_led, dispatch_req}, 0);
    chk("arst_count", alarm_count, 0);
    #1;
    rst = 1'b0;

    // Door and facility together from ARMED: straight to ALARM.
    tick(1);
    chk("d_arm", state, 1);
    tick(16);
    chk("d_armed", state, 2);
    door = 1'b1; fac = 1'b1;
    tick(1);
    door = 1'b0; fac = 1'b0;
    chk("both_state", state, 4);
    chk("both_count", alarm_count, 1);
    chk("both_req", dispatch_req, 1);
    tick(64);
    chk("d_silenced", state, 5);
    chk("d_req_pending", dispatch_req, 1);
    door = 1'b1; ack = 1'b1;
    tick(1);
    door = 1'b0; ack = 1'b0;
    chk("setwins_state", state, 4);
    chk("setwins_req", dispatch_req, 1);
    chk("setwins_count", alarm_count, 2);
    is_enabled = 1'b0;
    tick(1);
    chk("d_disarm_state", state, 0);
    chk("d_disarm_outs", {siren, strobe, armed_led}, 0);
    chk("d_disarm_req_kept", dispatch_req, 1);
    chk("d_disarm_count", alarm_count, 2);
    ack = 1'b1;
    tick(1);
    chk("d_ack_clear", dispatch_req, 0);
    tick(1);
    ack = 1'b0;
    chk("ack_idle_ignored", dispatch_req, 0);

    // Saturate alarm_count at 15 via repeated SILENCED re-entries.
    is_enabled = 1'b1;
    tick(17);
    chk("s_armed", state, 2);
    fac = 1'b1;
    tick(1);
    fac = 1'b0;
    chk("s_count3", alarm_count, 3);
    for (int i = 0; i < 12; i++) begin
      tick(64);
      fac = 1'b1;
      tick(1);
      fac = 1'b0;
    end
    chk("sat_count15", alarm_count, 15);
    tick(64);
    chk("sat_silenced", state, 5);
    fac = 1'b1;
    tick(1);
    fac = 1'b0;
    chk("sat_hold", alarm_count, 15);
    chk("sat_state", state, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
